hc4511_scan_ctrl: RTL and testbench

//   Upstream driver for the hc4511 BCD latch/decoder in a multiplexed N-digit display.

---
 rtl/hc4511_pkg.sv | 26 ++
 rtl/hc4511_lzb.sv | 25 ++
 rtl/hc4511_scan_ctrl.sv | 164 ++++++++++++++++
 tb/tb_hc4511_scan_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/hc4511_pkg.sv
// Shared types and constants for the hc4511 scan controller.
// State encoding, BCD digit width and a constant-foldable clog2.
package hc4511_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    LATCH = 2'd2,
    SHOW  = 2'd3
  } state_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hc4511_lzb.sv
// Leading-zero blanking mask: combinational, zero latency, no flow control.
// blank[i] is set when LZB is enabled and digits i..N_DIG-1 are all zero; digit 0 never blanks.
module hc4511_lzb
  import hc4511_pkg::*;
#(
  parameter int N_DIG = 4
) (
  input  logic [N_DIG*BCD_W-1:0] active_dat,
  input  logic                   lzb_en,
  output logic [N_DIG-1:0]       blank
);

  logic all_zero;

  always_comb begin
    blank    = '0;
    all_zero = 1'b1;
    // Walk down from the most significant digit, accumulating "all zero so far".
    for (int i = N_DIG - 1; i >= 1; i--) begin
      all_zero = all_zero & (active_dat[i*BCD_W +: BCD_W] == '0);
      blank[i] = lzb_en & all_zero;
    end
  end

endmodule

// File: rtl/hc4511_scan_ctrl.sv
// Multiplexed N-digit scan driver for an hc4511 decoder with double-buffered BCD word.
// Outputs registered (1 cycle after state decision); no backpressure, EN low parks the scan dark.
module hc4511_scan_ctrl
  import hc4511_pkg::*;
#(
  parameter int N_DIG     = 4,
  parameter int BLANK_CYC = 16,
  parameter int HOLD_CYC  = 1000
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   EN,
  input  logic                   LOAD,
  input  logic [BCD_W*N_DIG-1:0] BCD_IN,
  input  logic                   LZB_EN,
  input  logic                   LAMP_TEST,
  output logic [BCD_W-1:0]       A,
  output logic                   LE,
  output logic                   BI_N,
  output logic                   LT_N,
  output logic [N_DIG-1:0]       DIG_N,
  output logic                   FRAME_DONE
);

  localparam int W       = BCD_W * N_DIG;
  localparam int CNT_MAX = (BLANK_CYC > HOLD_CYC) ? BLANK_CYC : HOLD_CYC;
  localparam int CNT_W   = clog2(CNT_MAX + 1);
  localparam int IDX_W   = (clog2(N_DIG) < 1) ? 1 : clog2(N_DIG);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIG - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [W-1:0]       shadow_q, shadow_d;
  logic [W-1:0]       active_q, active_d;
  logic [BCD_W-1:0]   a_q, a_d;
  logic               le_q, le_d;
  logic               bi_n_q, bi_n_d;
  logic               lt_n_q, lt_n_d;
  logic [N_DIG-1:0]   dig_n_q, dig_n_d;
  logic               frame_done_q, frame_done_d;
  logic               wrap;
  logic [N_DIG-1:0]   blank;

  hc4511_lzb #(.N_DIG(N_DIG)) u_lzb (
    .active_dat (active_q),
    .lzb_en     (LZB_EN),
    .blank      (blank)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wrap     = 1'b0;
    shadow_d = LOAD ? BCD_IN : shadow_q;
    active_d = active_q;

    if (!EN) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = '0;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = LATCH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        LATCH: begin
          state_d = SHOW;
          cnt_d   = '0;
        end
        SHOW: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              // Frame boundary: a LOAD landing here goes straight to active via shadow_d.
              idx_d    = '0;
              wrap     = 1'b1;
              active_d = shadow_d;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output registers are decoded from the next state so they line up with state_q.
  always_comb begin
    a_d          = '0;
    le_d         = 1'b1;
    bi_n_d       = 1'b0;
    lt_n_d       = ~LAMP_TEST;
    dig_n_d      = '1;
    frame_done_d = wrap;
    case (state_d)
      BLANK: begin
        le_d = 1'b0;
        a_d  = active_d[BCD_W*idx_d +: BCD_W];
      end
      LATCH: a_d = active_d[BCD_W*idx_d +: BCD_W];
      SHOW: begin
        a_d            = active_d[BCD_W*idx_d +: BCD_W];
        dig_n_d[idx_d] = 1'b0;
        bi_n_d         = LAMP_TEST | ~blank[idx_d];
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      a_q          <= '0;
      le_q         <= 1'b1;
      bi_n_q       <= 1'b0;
      lt_n_q       <= 1'b1;
      dig_n_q      <= '1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      a_q          <= a_d;
      le_q         <= le_d;
      bi_n_q       <= bi_n_d;
      lt_n_q       <= lt_n_d;
      dig_n_q      <= dig_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign A          = a_q;
  assign LE         = le_q;
  assign BI_N       = bi_n_q;
  assign LT_N       = lt_n_q;
  assign DIG_N      = dig_n_q;
  assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_hc4511_scan_ctrl.sv
// Directed bench for hc4511_scan_ctrl with N_DIG=4, BLANK_CYC=2, HOLD_CYC=4 (slot 7, frame 28).
// Outputs are sampled on the falling edge; p counts cycles from the first BLANK cycle of a frame.
module tb_hc4511_scan_ctrl;

  logic        CLK;
  logic        RST_N;
  logic        EN;
  logic        LOAD;
  logic [15:0] BCD_IN;
  logic        LZB_EN;
  logic        LAMP_TEST;
  logic [3:0]  A;
  logic        LE;
  logic        BI_N;
  logic        LT_N;
  logic [3:0]  DIG_N;
  logic        FRAME_DONE;

  int          total;
  int          bad;
  logic [10:0] obs;
  logic [10:0] expv;

  hc4511_scan_ctrl #(.N_DIG(4), .BLANK_CYC(2), .HOLD_CYC(4)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .EN         (EN),
    .LOAD       (LOAD),
    .BCD_IN     (BCD_IN),
    .LZB_EN     (LZB_EN),
    .LAMP_TEST  (LAMP_TEST),
    .A          (A),
    .LE         (LE),
    .BI_N       (BI_N),
    .LT_N       (LT_N),
    .DIG_N      (DIG_N),
    .FRAME_DONE (FRAME_DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected {DIG_N, A, LE, BI_N, FRAME_DONE} at frame position p for a given active word.
  function automatic logic [10:0] exp_vec(input logic [15:0] word, input int p,
                                          input logic lzb, input logic lamp, input logic fd0);
    int         idx;
    int         pos;
    logic [3:0] dig;
    logic [3:0] a;
    logic       le;
    logic       bi;
    logic       blk;
    logic       fd;
    idx = p / 7;
    pos = p % 7;
    a   = 4'(word >> (4 * idx));
    dig = 4'b1111;
    if (pos >= 3) dig[idx] = 1'b0;
    le  = (pos >= 2);
    blk = lzb && (idx != 0) && ((word >> (4 * idx)) == 16'h0000);
    bi  = (pos >= 3) && (lamp || !blk);
    fd  = (p == 0) && fd0;
    return {dig, a, le, bi, fd};
  endfunction

  task automatic test_reset();
    RST_N = 1'b0; EN = 1'b0; LOAD = 1'b0; BCD_IN = '0; LZB_EN = 1'b0; LAMP_TEST = 1'b0;
    repeat (3) @(negedge CLK);
    total++; if (A !== 4'h0)        begin bad++; $display("FAIL rst_a got=%h exp=0", A); end
    total++; if (LE !== 1'b1)       begin bad++; $display("FAIL rst_le got=%b exp=1", LE); end
    total++; if (BI_N !== 1'b0)     begin bad++; $display("FAIL rst_bi_n got=%b exp=0", BI_N); end
    total++; if (LT_N !== 1'b1)     begin bad++; $display("FAIL rst_lt_n got=%b exp=1", LT_N); end
    total++; if (DIG_N !== 4'hF)    begin bad++; $display("FAIL rst_dig_n got=%b exp=1111", DIG_N); end
    total++; if (FRAME_DONE !== 0)  begin bad++; $display("FAIL rst_frame_done got=%b exp=0", FRAME_DONE); end
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    total++;
    if ({DIG_N, LE, BI_N} !== 6'b1111_1_0) begin
      bad++; $display("FAIL idle_dark got=%b exp=111110", {DIG_N, LE, BI_N});
    end
  endtask

  task automatic test_scan();
    EN = 1'b1; LOAD = 1'b1; BCD_IN = 16'h1234;
    @(negedge CLK);
    LOAD = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < 28; p++) begin
        expv = exp_vec((f == 0) ? 16'h0000 : 16'h1234, p, 1'b0, 1'b0, f == 1);
        obs  = {DIG_N, A, LE, BI_N, FRAME_DONE};
        total++;
        if (obs !== expv) begin bad++; $display("FAIL scan f=%0d p=%0d got=%b exp=%b", f, p, obs, expv); end
        @(negedge CLK);
      end
    end
  endtask

  task automatic test_double_buffer();
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < 28; p++) begin
        expv = exp_vec((f == 0) ? 16'h1234 : 16'h5678, p, 1'b0, 1'b0, 1'b1);
        obs  = {DIG_N, A, LE, BI_N, FRAME_DONE};
        total++;
        if (obs !== expv) begin bad++; $display("FAIL dbuf f=%0d p=%0d got=%b exp=%b", f, p, obs, expv); end
        if (f == 0 && p == 8) begin LOAD = 1'b1; BCD_IN = 16'h5678; end
        if (f == 0 && p == 9) LOAD = 1'b0;
        @(negedge CLK);
      end
    end
  endtask

  task automatic test_lzb();
    logic [15:0] w;
    LZB_EN = 1'b1;
    for (int f = 0; f < 3; f++) begin
      w = (f == 0) ? 16'h5678 : (f == 1) ? 16'h0700 : 16'h0000;
      for (int p = 0; p < 28; p++) begin
        expv = exp_vec(w, p, 1'b1, 1'b0, 1'b1);
        obs  = {DIG_N, A, LE, BI_N, FRAME_DONE};
        total++;
        if (obs !== expv) begin bad++; $display("FAIL lzb f=%0d p=%0d got=%b exp=%b", f, p, obs, expv); end
        if (p == 1 && f == 0) begin LOAD = 1'b1; BCD_IN = 16'h0700; end
        if (p == 1 && f == 1) begin LOAD = 1'b1; BCD_IN = 16'h0000; end
        if (p == 2) LOAD = 1'b0;
        @(negedge CLK);
      end
    end
  endtask

  task automatic test_lamp();
    LAMP_TEST = 1'b1;
    for (int p = 0; p < 28; p++) begin
      total++;
      if (LT_N !== (p == 0)) begin bad++; $display("FAIL lamp_lt_n p=%0d got=%b exp=%b", p, LT_N, p == 0); end
      expv = exp_vec(16'h0000, p, 1'b1, 1'b1, 1'b1);
      obs  = {DIG_N, A, LE, BI_N, FRAME_DONE};
      total++;
      if (obs !== expv) begin bad++; $display("FAIL lamp p=%0d got=%b exp=%b", p, obs, expv); end
      @(negedge CLK);
    end
    LAMP_TEST = 1'b0;
    LZB_EN    = 1'b0;
  endtask

  task automatic test_en_drop();
    for (int p = 0; p < 19; p++) begin
      expv = exp_vec(16'h0000, p, 1'b0, 1'b0, 1'b1);
      obs  = {DIG_N, A, LE, BI_N, FRAME_DONE};
      total++;
      if (obs !== expv) begin bad++; $display("FAIL endrop_pre p=%0d got=%b exp=%b", p, obs, expv); end
      if (p == 1) begin
        total++;
        if (LT_N !== 1'b1) begin bad++; $display("FAIL lamp_off_lt_n got=%b exp=1", LT_N); end
      end
      if (p == 2) begin LOAD = 1'b1; BCD_IN = 16'h4321; end
      if (p == 3) LOAD = 1'b0;
      if (p == 18) EN = 1'b0;
      @(negedge CLK);
    end
    for (int c = 0; c < 40; c++) begin
      total++;
      if ({DIG_N, LE, BI_N, FRAME_DONE} !== 7'b1111_1_0_0) begin
        bad++; $display("FAIL endrop_idle c=%0d got=%b exp=1111100", c, {DIG_N, LE, BI_N, FRAME_DONE});
      end
      @(negedge CLK);
    end
    EN = 1'b1;
    @(negedge CLK);
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < 28; p++) begin
        expv = exp_vec((f == 0) ? 16'h0000 : 16'h4321, p, 1'b0, 1'b0, f == 1);
        obs  = {DIG_N, A, LE, BI_N, FRAME_DONE};
        total++;
        if (obs !== expv) begin bad++; $display("FAIL restart f=%0d p=%0d got=%b exp=%b", f, p, obs, expv); end
        @(negedge CLK);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int p = 0; p < 3; p++) begin
      expv = exp_vec(16'h4321, p, 1'b0, 1'b0, 1'b1);
      obs  = {DIG_N, A, LE, BI_N, FRAME_DONE};
      total++;
      if (obs !== expv) begin bad++; $display("FAIL prelatch p=%0d got=%b exp=%b", p, obs, expv); end
      if (p < 2) @(negedge CLK);
    end
    #1 RST_N = 1'b0;
    EN = 1'b0;
    #1;
    total++;
    if ({A, LE, BI_N, LT_N, DIG_N, FRAME_DONE} !== 12'b0000_1_0_1_1111_0) begin
      bad++; $display("FAIL rst_latch got=%b exp=000010111110", {A, LE, BI_N, LT_N, DIG_N, FRAME_DONE});
    end
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    EN    = 1'b1;
    @(negedge CLK);
    for (int f = 0; f < 3; f++) begin
      for (int p = 0; p < 28; p++) begin
        expv = exp_vec((f == 0) ? 16'h0000 : 16'h8765, p, 1'b0, 1'b0, f != 0);
        obs  = {DIG_N, A, LE, BI_N, FRAME_DONE};
        total++;
        if (obs !== expv) begin bad++; $display("FAIL wrapload f=%0d p=%0d got=%b exp=%b", f, p, obs, expv); end
        if (f == 0 && p == 27) begin LOAD = 1'b1; BCD_IN = 16'h8765; end
        if (f == 1 && p == 0) LOAD = 1'b0;
        @(negedge CLK);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_scan();
    test_double_buffer();
    test_lzb();
    test_lamp();
    test_en_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
